// File: rtl/dma_engine_2d_pkg.sv
// dma_engine_2d_pkg: register map, control bit positions and FSM states for the 2D DMA
package dma_engine_2d_pkg;
  localparam logic [3:0] REG_CTRL       = 4'd0;
  localparam logic [3:0] REG_CMD        = 4'd1;
  localparam logic [3:0] REG_SRC        = 4'd2;
  localparam logic [3:0] REG_DST        = 4'd3;
  localparam logic [3:0] REG_WORDS      = 4'd4;
  localparam logic [3:0] REG_LINES      = 4'd5;
  localparam logic [3:0] REG_SRC_STRIDE = 4'd6;
  localparam logic [3:0] REG_DST_STRIDE = 4'd7;
  localparam int CTRL_GO     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CMD_ABORT   = 0;
  localparam int CMD_IRQ_CLR = 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE, ABORT} state_t;
endpackage

// File: rtl/dma_fifo.sv
// dma_fifo: synchronous show-ahead FIFO with flush; head word is visible on data_out while non-empty
module dma_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty    = count == '0;
  assign do_pop   = pop && !empty;
  assign do_push  = push && (count != (AW+1)'(DEPTH) || do_pop);
  assign data_out = mem[rp];
  always_ff @(posedge clk) if (do_push) mem[wp] <= data_in;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + AW'(do_push);
      rp    <= rp + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/dma_engine_2d.sv
// dma_engine_2d: CPU-programmed 2D rectangle copy, pipelined Avalon-MM read master -> FIFO -> write master
module dma_engine_2d
  import dma_engine_2d_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 16,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                    clock,
  input  logic                    clock_sreset,
  input  logic [3:0]              s_address,
  input  logic [31:0]             s_writedata,
  output logic [31:0]             s_readdata,
  input  logic                    s_read,
  input  logic                    s_write,
  output logic                    s_waitrequest,
  output logic                    s_irq,
  output logic [ADDR_WIDTH-1:0]   mr_address,
  output logic [DATA_WIDTH/8-1:0] mr_byteenable,
  output logic                    mr_read,
  input  logic                    mr_waitrequest,
  input  logic [DATA_WIDTH-1:0]   mr_readdata,
  input  logic                    mr_readdatavalid,
  output logic [ADDR_WIDTH-1:0]   mw_address,
  output logic [DATA_WIDTH/8-1:0] mw_byteenable,
  output logic [DATA_WIDTH-1:0]   mw_writedata,
  output logic                    mw_write,
  input  logic                    mw_waitrequest
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  state_t state, state_nx;
  logic irq_en, irq_pend, rd_phase, busy, room, push, pop, flush, rd_acc;
  logic go, abort, irq_clr, empty_xfer, rd_eol, wr_eol, rd_act, wr_act, fifo_empty;
  logic [31:0] src, dst, words, lines, src_stride, dst_stride, rd_mux;
  logic [31:0] words_w, lines_w, rd_col, rd_row, wr_col, wr_row;
  addr_t sstride_w, dstride_w, rd_base, wr_base;
  logic [CW-1:0] outst, fifo_count;
  assign go            = s_write && s_address == REG_CTRL && s_writedata[CTRL_GO];
  assign abort         = s_write && s_address == REG_CMD && s_writedata[CMD_ABORT];
  assign irq_clr       = s_write && s_address == REG_CMD && s_writedata[CMD_IRQ_CLR];
  assign empty_xfer    = words == '0 || lines == '0;
  assign rd_acc        = mr_read && !mr_waitrequest;
  assign pop           = mw_write && !mw_waitrequest;
  assign rd_eol        = rd_col == words_w - 1;
  assign wr_eol        = wr_col == words_w - 1;
  assign s_waitrequest = s_read && !rd_phase;
  assign s_irq         = irq_pend && irq_en;
  assign mr_byteenable = '1;
  assign mw_byteenable = '1;
  always_ff @(posedge clock) state <= clock_sreset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = go ? (empty_xfer ? DONE : RUN) : IDLE;
      RUN:     state_nx = abort ? ABORT : (wr_act ? RUN : DONE);
      DONE:    state_nx = abort ? ABORT : IDLE;
      ABORT:   state_nx = outst == '0 ? IDLE : ABORT;
      default: state_nx = IDLE;
    endcase
  end
  // Credit check: every issued read must already own a FIFO slot, so readdatavalid can never overflow it.
  always_comb begin
    busy     = state != IDLE;
    room     = 32'(fifo_count) + 32'(outst) < 32'(FIFO_DEPTH) && 32'(outst) < 32'(MAX_OUTSTANDING);
    mr_read  = state == RUN && rd_act && room;
    mw_write = state == RUN && !fifo_empty;
    push     = state == RUN && mr_readdatavalid;
    flush    = state == ABORT;
  end
  always_comb begin
    rd_mux = '0;
    case (s_address)
      REG_CTRL:       rd_mux = {29'b0, irq_pend, busy, irq_en};
      REG_SRC:        rd_mux = src;
      REG_DST:        rd_mux = dst;
      REG_WORDS:      rd_mux = words;
      REG_LINES:      rd_mux = lines;
      REG_SRC_STRIDE: rd_mux = src_stride;
      REG_DST_STRIDE: rd_mux = dst_stride;
      default:        rd_mux = '0;
    endcase
  end
  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      {irq_en, irq_pend, rd_phase} <= '0;
      {src, dst, words, lines, src_stride, dst_stride, s_readdata} <= '0;
    end else begin
      if (s_write && s_address == REG_CTRL) irq_en <= s_writedata[CTRL_IRQ_EN];
      if (s_write && s_address == REG_SRC) src <= s_writedata;
      if (s_write && s_address == REG_DST) dst <= s_writedata;
      if (s_write && s_address == REG_WORDS) words <= s_writedata;
      if (s_write && s_address == REG_LINES) lines <= s_writedata;
      if (s_write && s_address == REG_SRC_STRIDE) src_stride <= s_writedata;
      if (s_write && s_address == REG_DST_STRIDE) dst_stride <= s_writedata;
      if (s_read && !rd_phase) s_readdata <= rd_mux;
      rd_phase <= s_read && !rd_phase;
      irq_pend <= state == DONE ? 1'b1 : (irq_clr ? 1'b0 : irq_pend);
    end
  end
  always_ff @(posedge clock) begin
    if (clock_sreset) outst <= '0;
    else outst <= outst + CW'(rd_acc) - CW'(mr_readdatavalid && outst != '0);
  end
  // Working copies are latched at go so register writes during a transfer only affect the next one.
  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      {words_w, lines_w, rd_col, rd_row, wr_col, wr_row} <= '0;
      {sstride_w, dstride_w, rd_base, wr_base, mr_address, mw_address} <= '0;
      {rd_act, wr_act} <= '0;
    end else if (state == IDLE && go) begin
      words_w    <= words;
      lines_w    <= lines;
      sstride_w  <= addr_t'(src_stride);
      dstride_w  <= addr_t'(dst_stride);
      rd_base    <= addr_t'(src);
      mr_address <= addr_t'(src);
      wr_base    <= addr_t'(dst);
      mw_address <= addr_t'(dst);
      {rd_col, rd_row, wr_col, wr_row} <= '0;
      rd_act     <= !empty_xfer;
      wr_act     <= !empty_xfer;
    end else begin
      if (rd_acc) begin
        rd_col     <= rd_eol ? '0 : rd_col + 1;
        rd_row     <= rd_eol ? rd_row + 1 : rd_row;
        rd_base    <= rd_eol ? rd_base + sstride_w : rd_base;
        mr_address <= rd_eol ? rd_base + sstride_w : mr_address + addr_t'(BYTES);
        rd_act     <= !(rd_eol && rd_row == lines_w - 1);
      end
      if (pop) begin
        wr_col     <= wr_eol ? '0 : wr_col + 1;
        wr_row     <= wr_eol ? wr_row + 1 : wr_row;
        wr_base    <= wr_eol ? wr_base + dstride_w : wr_base;
        mw_address <= wr_eol ? wr_base + dstride_w : mw_address + addr_t'(BYTES);
        wr_act     <= !(wr_eol && wr_row == lines_w - 1);
      end
    end
  end
  dma_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clock), .rst(clock_sreset), .push(push), .pop(pop), .flush(flush),
    .data_in(mr_readdata), .data_out(mw_writedata), .count(fifo_count), .empty(fifo_empty)
  );
endmodule
